load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
// - Sits between the execute stage and the byte-wide data memory; owns every load/store the core issues.
// - Accepts one word/half/byte request, checks alignment and range, then runs one memory byte access per cycle, little-endian.
// - Loads are assembled and sign/zero-extended before return; stores write only the addressed bytes.
// PARAMETERS
// - ADDR_W     32  request/memory address width
// - MEM_BYTES  32  size of the data memory in bytes; any accessed byte >= MEM_BYTES is a fault
// PORTS
// - clk            in   1       rising-edge clock
// - reset          in   1       asynchronous, active-low reset
// - req_valid      in   1       request present
// - req_ready      out  1       unit idle; request is accepted when req_valid && req_ready at a rising edge
// - req_write      in   1       1 = store, 0 = load
// - req_size       in   2       00 byte, 01 half, 10 word, 11 illegal
// - req_unsigned   in   1       loads only: 1 = zero-extend, 0 = sign-extend
// - req_addr       in   ADDR_W  byte address
// - req_wdata      in   32      store data; low bytes are used for byte/half stores
// - resp_valid     out  1       one-cycle completion pulse
// - resp_err       out  1       valid with resp_valid: misaligned access, illegal size, or out-of-range access
// - resp_rdata     out  32      load result, valid with resp_valid; 0 for stores and errors
// - mem_addr       out  ADDR_W  byte address to the data memory
// - mem_read       out  1       byte read strobe
// - mem_write      out  1       byte write strobe; the memory commits mem_wdata in this cycle
// - mem_wdata      out  8       byte to write
// - mem_rdata      in   8       combinational read byte for mem_addr
// BEHAVIOUR
// - Reset values: state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
// - FSM states: IDLE -> ACCESS -> RESP -> IDLE. The fault path is IDLE -> RESP.
// - IDLE: req_ready=1. On accept, register the operation and set N = 1/2/4 bytes. Fault conditions:
//     - size 11
//     - half access with addr[0] != 0
//     - word access with addr[1:0] != 0
//     - addr + N - 1 >= MEM_BYTES
//   On a fault, set resp_err and go to RESP. Otherwise clear the byte index i and go to ACCESS.
// - ACCESS: req_ready=0. Drive mem_addr = base + i and exactly one strobe, mem_read or mem_write.
//     - Store: mem_wdata = wdata[8i+7:8i].
//     - Load: on the rising edge, capture mem_rdata into byte lane i.
//     - i increments every cycle. After byte N-1, go to RESP.
// - RESP: resp_valid=1 for exactly one cycle, then return to IDLE.
//     - Load result: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through.
//     - The next request can be accepted in the cycle after RESP.
// - Outputs are all registered; strobes are 0 outside ACCESS.
// - Latency, accept edge to resp_valid: N+1 cycles (byte 2, half 3, word 5). Faults take 1 cycle with no memory strobes.
// - Exactly N strobe cycles occur per legal request; strobes are never issued during RESP or IDLE.
// - req_valid during ACCESS/RESP is ignored because req_ready=0. The requester holds the request until it is accepted.
// - Request inputs are sampled only on the accept edge; later changes do not affect an operation in flight.
// - Reset mid-operation: abort immediately and deassert the strobes. Bytes already written stay written, and no response is issued.
// - Address arithmetic uses ADDR_W bits with no wrap-around; the range check rejects any access that would cross MEM_BYTES.
// STRUCTURE
// - Package lsu_pkg holds:
//     - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILLEGAL
//     - FSM state enum (IDLE, ACCESS, RESP)
//     - a function returning N from the size
// - Sub-module lsu_load_extend: combinational; takes the 32-bit assembled bytes, size and unsigned flag and returns the extended result.
// TESTING
// - Memory preloaded 68 00 00 00 at 0..3; LW addr 0 -> resp_valid on accept+5, rdata 0x00000068, err 0, 4 mem_read pulses at addresses 0,1,2,3.
// - Byte 0x80 at addr 4 -> LB returns 0xFFFFFF80 on accept+2; LBU returns 0x00000080.
// - SH wdata 0x1234ABCD, addr 8 -> mem_write at 8 with CD, then at 9 with AB, then resp. A following LH at 8 returns 0xFFFFABCD; LHU returns 0x0000ABCD.
// - Fault cases, each with resp_err=1 and rdata 0 on accept+1, and zero strobes:
//     - LW at addr 2
//     - LH at addr 5
//     - size 11
//     - LW at addr 30 (MEM_BYTES=32)
// - SW 0xDDCCBBAA at 12, reset asserted after the second write cycle -> bytes 12,13 = AA,BB; 14,15 unchanged; no resp_valid; all outputs at reset values; req_ready=1 after release.
// - req_valid held with different addresses during ACCESS -> req_ready=0, only the first request is served; a back-to-back request is accepted in the cycle after RESP.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings, FSM states and size helper for the load/store unit
// Contents:
//   SZ_*         request size encodings
//   lsu_state_e  FSM states IDLE / ACCESS / RESP
//   size_bytes   number of bytes touched by a given size (illegal maps to 1)
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_e;

    // Illegal size returns 1 so the range arithmetic stays well defined;
    // the request is rejected on the size check anyway.
    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            SZ_HALF: size_bytes = 3'd2;
            SZ_WORD: size_bytes = 3'd4;
            default: size_bytes = 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// rtl/lsu_load_extend.sv - sign/zero extension of assembled load bytes
// Ports:
//   i_bytes     little-endian assembled bytes (lane 0 = lowest address)
//   i_size      request size encoding
//   i_unsigned  1 = zero-extend, 0 = sign-extend (byte/half only)
//   o_data      extended load result
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] i_bytes,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    always_comb begin
        o_data = i_bytes;
        case (i_size)
            SZ_BYTE: o_data = i_unsigned ? {24'h000000, i_bytes[7:0]}
                                         : {{24{i_bytes[7]}}, i_bytes[7:0]};
            SZ_HALF: o_data = i_unsigned ? {16'h0000, i_bytes[15:0]}
                                         : {{16{i_bytes[15]}}, i_bytes[15:0]};
            default: o_data = i_bytes;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte-serial load/store unit between execute stage and byte-wide data memory
// Ports:
//   i_clk, i_rst_n                    clock, asynchronous active-low reset
//   i_req_*/o_req_ready               request handshake (write, size, unsigned, addr, wdata)
//   o_resp_valid/o_resp_err/o_resp_rdata  one-cycle completion pulse with status and load data
//   o_mem_addr/o_mem_read/o_mem_write/o_mem_wdata/i_mem_rdata  one byte access per cycle
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_write,
    input  logic [1:0]        i_req_size,
    input  logic              i_req_unsigned,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [31:0]       i_req_wdata,
    output logic              o_resp_valid,
    output logic              o_resp_err,
    output logic [31:0]       o_resp_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_read,
    output logic              o_mem_write,
    output logic [7:0]        o_mem_wdata,
    input  logic [7:0]        i_mem_rdata
);

    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

    lsu_state_e        r_state;
    logic              r_write;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [31:0]       r_wdata;
    logic [31:0]       r_bytes;
    logic [1:0]        r_idx;
    logic [1:0]        r_last;
    logic              r_req_ready;
    logic              r_resp_valid;
    logic              r_resp_err;
    logic [31:0]       r_resp_rdata;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [7:0]        r_mem_wdata;

    logic [2:0]        w_n;
    logic [ADDR_W:0]   w_end;
    logic              w_fault;
    logic [1:0]        w_idx_next;
    logic [7:0]        w_wbyte_next;
    logic [31:0]       w_merged;
    logic [31:0]       w_ext;

    assign w_n = size_bytes(i_req_size);
    // One extra bit so the last-byte address never wraps at the top of the address space.
    assign w_end = {1'b0, i_req_addr} + (ADDR_W+1)'(w_n) - (ADDR_W+1)'(1);

    assign w_fault = (i_req_size == SZ_ILLEGAL)
                   || ((i_req_size == SZ_HALF) && i_req_addr[0])
                   || ((i_req_size == SZ_WORD) && (i_req_addr[1:0] != 2'b00))
                   || (w_end >= MEM_LIMIT);

    assign w_idx_next   = r_idx + 2'd1;
    assign w_wbyte_next = r_wdata[{w_idx_next, 3'b000} +: 8];

    // The final byte is still on i_mem_rdata when the response is registered,
    // so extension works on the captured lanes with the current lane patched in.
    always_comb begin
        w_merged = r_bytes;
        w_merged[{r_idx, 3'b000} +: 8] = i_mem_rdata;
    end

    lsu_load_extend u_load_extend (
        .i_bytes    (w_merged),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_data     (w_ext)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_write      <= 1'b0;
            r_size       <= SZ_BYTE;
            r_unsigned   <= 1'b0;
            r_wdata      <= 32'h0;
            r_bytes      <= 32'h0;
            r_idx        <= 2'd0;
            r_last       <= 2'd0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'h0;
            r_mem_addr   <= '0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_wdata  <= 8'h00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_req_valid && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        r_write     <= i_req_write;
                        r_size      <= i_req_size;
                        r_unsigned  <= i_req_unsigned;
                        r_wdata     <= i_req_wdata;
                        r_bytes     <= 32'h0;
                        r_idx       <= 2'd0;
                        r_last      <= 2'(w_n - 3'd1);
                        if (w_fault) begin
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= 32'h0;
                            r_state      <= RESP;
                        end else begin
                            r_mem_addr  <= i_req_addr;
                            r_mem_read  <= !i_req_write;
                            r_mem_write <= i_req_write;
                            r_mem_wdata <= i_req_write ? i_req_wdata[7:0] : 8'h00;
                            r_state     <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (!r_write) begin
                        r_bytes <= w_merged;
                    end
                    if (r_idx == r_last) begin
                        r_mem_read   <= 1'b0;
                        r_mem_write  <= 1'b0;
                        r_mem_wdata  <= 8'h00;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= r_write ? 32'h0 : w_ext;
                        r_state      <= RESP;
                    end else begin
                        r_idx       <= w_idx_next;
                        r_mem_addr  <= r_mem_addr + ADDR_W'(1);
                        r_mem_wdata <= r_write ? w_wbyte_next : 8'h00;
                    end
                end
                RESP: begin
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= 32'h0;
                    r_req_ready  <= 1'b1;
                    r_state      <= IDLE;
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign o_req_ready  = r_req_ready;
    assign o_resp_valid = r_resp_valid;
    assign o_resp_err   = r_resp_err;
    assign o_resp_rdata = r_resp_rdata;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_read   = r_mem_read;
    assign o_mem_write  = r_mem_write;
    assign o_mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic [7:0]  mem [0:31];
    logic        pl_en;
    logic [4:0]  pl_addr;
    logic [7:0]  pl_data;

    int          tests;
    int          errors;
    int          rd_cnt;
    int          wr_cnt;
    int          resp_cnt;
    logic [31:0] rd_log [0:7];
    logic [31:0] wr_log [0:7];
    logic [7:0]  wd_log [0:7];

    load_store_unit #(.ADDR_W(32), .MEM_BYTES(32)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_write    (req_write),
        .i_req_size     (req_size),
        .i_req_unsigned (req_unsigned),
        .i_req_addr     (req_addr),
        .i_req_wdata    (req_wdata),
        .o_resp_valid   (resp_valid),
        .o_resp_err     (resp_err),
        .o_resp_rdata   (resp_rdata),
        .o_mem_addr     (mem_addr),
        .o_mem_read     (mem_read),
        .o_mem_write    (mem_write),
        .o_mem_wdata    (mem_wdata),
        .i_mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = (mem_addr < 32) ? mem[mem_addr[4:0]] : 8'h00;

    always @(posedge clk) begin
        if (mem_write && mem_addr < 32)
            mem[mem_addr[4:0]] <= mem_wdata;
        else if (pl_en)
            mem[pl_addr] <= pl_data;
    end

    // Strobe / response monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_read) begin
            if (rd_cnt < 8) rd_log[rd_cnt] = mem_addr;
            rd_cnt = rd_cnt + 1;
        end
        if (mem_write) begin
            if (wr_cnt < 8) begin
                wr_log[wr_cnt] = mem_addr;
                wd_log[wr_cnt] = mem_wdata;
            end
            wr_cnt = wr_cnt + 1;
        end
        if (resp_valid) resp_cnt = resp_cnt + 1;
    end

    task automatic preload(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    task automatic clear_counts();
        rd_cnt = 0; wr_cnt = 0; resp_cnt = 0;
    endtask

    // Issues one request, returns cycles from accept edge until resp_valid is seen.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic er);
        int guard;
        @(negedge clk);
        clear_counts();
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = wd;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 99; rd = 32'hDEAD_DEAD; er = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = k; rd = resp_rdata; er = resp_err;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        tests++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b expected 1", req_ready); end
        tests++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b expected 0", resp_valid); end
        tests++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err got %b expected 0", resp_err); end
        tests++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h expected 0", resp_rdata); end
        tests++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("FAIL reset_strobes got %b%b expected 00", mem_read, mem_write); end
        tests++; if (mem_addr !== 32'h0 || mem_wdata !== 8'h0) begin errors++; $display("FAIL reset_mem_bus got %h/%h expected 0/0", mem_addr, mem_wdata); end
    endtask

    task automatic test_load_word();
        int lat; logic [31:0] rd; logic er;
        do_req(1'b0, 2'b10, 1'b0, 32'd0, 32'h0, lat, rd, er);
        tests++; if (lat !== 5) begin errors++; $display("FAIL lw_latency got %0d expected 5", lat); end
        tests++; if (rd !== 32'h0000_0068) begin errors++; $display("FAIL lw_rdata got %h expected 00000068", rd); end
        tests++; if (er !== 1'b0) begin errors++; $display("FAIL lw_err got %b expected 0", er); end
        tests++; if (rd_cnt !== 4 || wr_cnt !== 0) begin errors++; $display("FAIL lw_strobes got rd %0d wr %0d expected 4 0", rd_cnt, wr_cnt); end
        for (int k = 0; k < 4; k++) begin
            tests++; if (rd_log[k] !== 32'(k)) begin errors++; $display("FAIL lw_addr%0d got %h expected %h", k, rd_log[k], 32'(k)); end
        end
    endtask

    task automatic test_load_byte();
        int lat; logic [31:0] rd; logic er;
        do_req(1'b0, 2'b00, 1'b0, 32'd4, 32'h0, lat, rd, er);
        tests++; if (lat !== 2) begin errors++; $display("FAIL lb_latency got %0d expected 2", lat); end
        tests++; if (rd !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_rdata got %h expected ffffff80", rd); end
        tests++; if (rd_cnt !== 1 || rd_log[0] !== 32'd4) begin errors++; $display("FAIL lb_strobe got cnt %0d addr %h expected 1 4", rd_cnt, rd_log[0]); end
        do_req(1'b0, 2'b00, 1'b1, 32'd4, 32'h0, lat, rd, er);
        tests++; if (rd !== 32'h0000_0080 || er !== 1'b0) begin errors++; $display("FAIL lbu_rdata got %h err %b expected 00000080 0", rd, er); end
        do_req(1'b0, 2'b00, 1'b0, 32'd31, 32'h0, lat, rd, er);
        tests++; if (rd !== 32'h0000_007F || er !== 1'b0) begin errors++; $display("FAIL lb_last_byte got %h err %b expected 0000007f 0", rd, er); end
    endtask

    task automatic test_store_half();
        int lat; logic [31:0] rd; logic er;
        do_req(1'b1, 2'b01, 1'b0, 32'd8, 32'h1234_ABCD, lat, rd, er);
        tests++; if (lat !== 3) begin errors++; $display("FAIL sh_latency got %0d expected 3", lat); end
        tests++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL sh_resp got %h err %b expected 0 0", rd, er); end
        tests++; if (wr_cnt !== 2 || rd_cnt !== 0) begin errors++; $display("FAIL sh_strobes got wr %0d rd %0d expected 2 0", wr_cnt, rd_cnt); end
        tests++; if (wr_log[0] !== 32'd8 || wd_log[0] !== 8'hCD) begin errors++; $display("FAIL sh_byte0 got %h/%h expected 8/cd", wr_log[0], wd_log[0]); end
        tests++; if (wr_log[1] !== 32'd9 || wd_log[1] !== 8'hAB) begin errors++; $display("FAIL sh_byte1 got %h/%h expected 9/ab", wr_log[1], wd_log[1]); end
        tests++; if (mem[10] !== 8'h00) begin errors++; $display("FAIL sh_untouched got %h expected 00", mem[10]); end
        do_req(1'b0, 2'b01, 1'b0, 32'd8, 32'h0, lat, rd, er);
        tests++; if (rd !== 32'hFFFF_ABCD || lat !== 3) begin errors++; $display("FAIL lh_rdata got %h lat %0d expected ffffabcd 3", rd, lat); end
        do_req(1'b0, 2'b01, 1'b1, 32'd8, 32'h0, lat, rd, er);
        tests++; if (rd !== 32'h0000_ABCD) begin errors++; $display("FAIL lhu_rdata got %h expected 0000abcd", rd); end
    endtask

    task automatic test_faults();
        logic [1:0]  f_size [0:4];
        logic [31:0] f_addr [0:4];
        int lat; logic [31:0] rd; logic er;
        f_size[0] = 2'b10; f_addr[0] = 32'd2;
        f_size[1] = 2'b01; f_addr[1] = 32'd5;
        f_size[2] = 2'b11; f_addr[2] = 32'd0;
        f_size[3] = 2'b10; f_addr[3] = 32'd30;
        f_size[4] = 2'b01; f_addr[4] = 32'hFFFF_FFFE;
        for (int k = 0; k < 5; k++) begin
            do_req(1'b0, f_size[k], 1'b0, f_addr[k], 32'h0, lat, rd, er);
            tests++;
            if (lat !== 1 || er !== 1'b1 || rd !== 32'h0 || rd_cnt !== 0 || wr_cnt !== 0) begin
                errors++;
                $display("FAIL fault%0d got lat %0d err %b rdata %h strobes %0d expected 1 1 0 0",
                         k, lat, er, rd, rd_cnt + wr_cnt);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        clear_counts();
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'd12; req_wdata = 32'hDDCC_BBAA;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++; if (mem_read !== 1'b0 || mem_write !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1
                     || mem_addr !== 32'h0 || mem_wdata !== 8'h0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
            errors++; $display("FAIL rst_mid_outputs got rd %b wr %b rv %b rdy %b addr %h expected 0 0 0 1 0",
                               mem_read, mem_write, resp_valid, req_ready, mem_addr);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (mem[12] !== 8'hAA || mem[13] !== 8'hBB) begin errors++; $display("FAIL rst_mid_written got %h %h expected aa bb", mem[12], mem[13]); end
        tests++; if (mem[14] !== 8'h33 || mem[15] !== 8'h44) begin errors++; $display("FAIL rst_mid_unwritten got %h %h expected 33 44", mem[14], mem[15]); end
        tests++; if (resp_cnt !== 0) begin errors++; $display("FAIL rst_mid_no_resp got %0d expected 0", resp_cnt); end
        tests++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %b expected 1", req_ready); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        clear_counts();
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'd4; req_wdata = 32'h0;
        @(posedge clk);
        @(negedge clk);
        tests++; if (req_ready !== 1'b0 || mem_read !== 1'b1 || mem_addr !== 32'd4) begin
            errors++; $display("FAIL b2b_access got rdy %b rd %b addr %h expected 0 1 4", req_ready, mem_read, mem_addr);
        end
        req_addr = 32'd0;
        @(negedge clk);
        tests++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hFFFF_FF80 || req_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_first_resp got rv %b rdata %h rdy %b expected 1 ffffff80 0", resp_valid, resp_rdata, req_ready);
        end
        req_addr = 32'd8;
        @(negedge clk);
        tests++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_read !== 1'b0) begin
            errors++; $display("FAIL b2b_after_resp got rdy %b rv %b rd %b expected 1 0 0", req_ready, resp_valid, mem_read);
        end
        req_addr = 32'd0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        tests++; if (mem_read !== 1'b1 || mem_addr !== 32'd0) begin
            errors++; $display("FAIL b2b_second_access got rd %b addr %h expected 1 0", mem_read, mem_addr);
        end
        @(negedge clk);
        tests++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0000_0068) begin
            errors++; $display("FAIL b2b_second_resp got rv %b rdata %h expected 1 00000068", resp_valid, resp_rdata);
        end
        @(negedge clk);
        tests++; if (rd_cnt !== 2 || resp_cnt !== 2) begin
            errors++; $display("FAIL b2b_counts got reads %0d resps %0d expected 2 2", rd_cnt, resp_cnt);
        end
    endtask

    initial begin
        tests = 0; errors = 0;
        rd_cnt = 0; wr_cnt = 0; resp_cnt = 0;
        rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        pl_en = 1'b0; pl_addr = 5'd0; pl_data = 8'h00;
        for (int k = 0; k < 32; k++) preload(5'(k), 8'h00);
        preload(5'd0, 8'h68);
        preload(5'd4, 8'h80);
        preload(5'd12, 8'h11);
        preload(5'd13, 8'h22);
        preload(5'd14, 8'h33);
        preload(5'd15, 8'h44);
        preload(5'd31, 8'h7F);
        @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_load_word();
        test_load_byte();
        test_store_half();
        test_faults();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
